// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one ADD/AND ALU, one transaction in flight.
// Optional per-requester grant counters are enabled by defining ARB_GRANT_CNT_EN.
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_op,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_op,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   input  logic             rsp_ready,
`ifdef ARB_GRANT_CNT_EN
   output logic             busy,
   output logic [7:0]       gnt_cnt0,
   output logic [7:0]       gnt_cnt1
`else
   output logic             busy
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             op_q, op_d;
   logic             id_q, id_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;
   logic             grant0, grant1;
   logic [WIDTH:0]   sum_c;

   assign sum_c = {1'b0, a_q} + {1'b0, b_q};

   // Next-state, arbitration and ALU evaluation
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      id_d         = id_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_carry_d  = rsp_carry_q;
      grant0       = 1'b0;
      grant1       = 1'b0;
      case (state_q)
         IDLE: begin
            grant0 = req0_valid & (~req1_valid | last_grant_q);
            grant1 = req1_valid & (~req0_valid | ~last_grant_q);
            if (grant0 | grant1) begin
               state_d      = EXEC;
               last_grant_d = grant1;
               id_d         = grant1;
               a_d          = grant1 ? req1_a  : req0_a;
               b_d          = grant1 ? req1_b  : req0_b;
               op_d         = grant1 ? req1_op : req0_op;
            end
         end
         EXEC: begin
            state_d  = RESP;
            rsp_id_d = id_q;
            if (op_q) begin
               rsp_data_d  = a_q & b_q;
               rsp_carry_d = 1'b0;
            end else begin
               rsp_data_d  = sum_c[WIDTH-1:0];
               rsp_carry_d = sum_c[WIDTH];
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rsp_valid_d = (state_d == RESP);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 1'b0;
         id_q         <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         id_q         <= id_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Readies are the combinational grant, forced low while reset is held
   assign req0_ready = grant0 & ~reset;
   assign req1_ready = grant1 & ~reset;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_carry  = rsp_carry_q;
   assign busy       = busy_q;

`ifdef ARB_GRANT_CNT_EN
   logic [7:0] gnt_cnt0_q, gnt_cnt1_q;

   // Saturating accepted-transaction counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
      end else begin
         if (grant0 && gnt_cnt0_q != 8'hFF) gnt_cnt0_q <= gnt_cnt0_q + 8'd1;
         if (grant1 && gnt_cnt1_q != 8'hFF) gnt_cnt1_q <= gnt_cnt1_q + 8'd1;
      end
   end

   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: accepted requests push expected results,
// a monitor compares every presented response.
module tb_alu_share_arbiter;
   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_op = 1'b0, req1_op = 1'b0;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_id, rsp_carry;
   logic [W-1:0] rsp_data;
   logic         rsp_ready = 1'b1;
   logic         busy;
`ifdef ARB_GRANT_CNT_EN
   logic [7:0]   gnt_cnt0, gnt_cnt1;
`endif

   typedef struct packed {
      logic         id;
      logic         carry;
      logic [W-1:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   int   grant_log[$];
   int   checks = 0;
   int   errors = 0;
   int   resp_count = 0;

   alu_share_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
      .rsp_ready(rsp_ready),
`ifdef ARB_GRANT_CNT_EN
      .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`else
      .busy(busy)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rsp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic op);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      model.id = id;
      if (op) begin
         model.data  = a & b;
         model.carry = 1'b0;
      end else begin
         model.data  = s[W-1:0];
         model.carry = s[W];
      end
   endfunction

   // Record accepted requests as expected responses
   always @(negedge clk) begin
      if (!reset) begin
         if (req0_ready) begin
            exp_q.push_back(model(1'b0, req0_a, req0_b, req0_op));
            grant_log.push_back(0);
         end
         if (req1_ready) begin
            exp_q.push_back(model(1'b1, req1_a, req1_b, req1_op));
            grant_log.push_back(1);
         end
      end
   end

   // A reset discards any in-flight transaction
   always @(posedge reset) exp_q.delete();

   // Monitor: compare every presented response, pop when consumed
   always @(negedge clk) begin
      if (!reset && rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
            chk("rsp_carry", 32'(rsp_carry), 32'(exp_q[0].carry));
            if (rsp_ready) begin
               void'(exp_q.pop_front());
               resp_count++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r0;
      // Reset state, readies suppressed while reset is high
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;

      // req0 ADD 0xF0 + 0x20 -> 0x10 carry 1, valid two cycles after ready
      req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h20; req0_op = 1'b0;
      @(negedge clk);
      chk("t1_ready0", 32'(req0_ready), 32'd1);
      chk("t1_ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("t1_exec_busy", 32'(busy), 32'd1);
      chk("t1_exec_valid", 32'(rsp_valid), 32'd0);
      chk("t1_exec_ready0", 32'(req0_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_id", 32'(rsp_id), 32'd0);
      chk("t1_rsp_data", 32'(rsp_data), 32'h10);
      chk("t1_rsp_carry", 32'(rsp_carry), 32'd1);
      tick();
      @(negedge clk);
      chk("t1_idle_busy", 32'(busy), 32'd0);
      chk("t1_idle_valid", 32'(rsp_valid), 32'd0);
      chk("t1_hold_data", 32'(rsp_data), 32'h10);
      tick();

      // req1 AND 0xAA & 0x0F with consumer stalled for 5 cycles
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h0F; req1_op = 1'b1;
      @(negedge clk);
      chk("t3_ready1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
         chk("t3_hold_data", 32'(rsp_data), 32'h0A);
         chk("t3_hold_carry", 32'(rsp_carry), 32'd0);
         chk("t3_hold_rdy0", 32'(req0_ready), 32'd0);
         chk("t3_hold_rdy1", 32'(req1_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("t3_release_valid", 32'(rsp_valid), 32'd1);
      tick();
      @(negedge clk);
      chk("t3_back_idle", 32'(busy), 32'd0);
      chk("t3_back_valid", 32'(rsp_valid), 32'd0);
      tick();

      // Both requesters continuously valid: alternating grants, one per 3 cycles
      grant_log.delete();
      r0 = resp_count;
      req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h01; req0_op = 1'b0;
      req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h02; req1_op = 1'b0;
      repeat (12) tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
      chk("t2_grant_count", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < grant_log.size()) chk("t2_grant_order", 32'(grant_log[i]), 32'(i % 2));
      chk("t2_resp_count", 32'(resp_count - r0), 32'd4);

      // Reset pulsed during EXEC: transaction dropped, tie then goes to requester 0
      req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 1'b0;
      @(negedge clk);
      chk("t4_ready0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("t4_exec_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("t4_rst_busy", 32'(busy), 32'd0);
      chk("t4_rst_valid", 32'(rsp_valid), 32'd0);
      chk("t4_rst_data", 32'(rsp_data), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
      end
      tick();
      req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06; req0_op = 1'b1;
      req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80; req1_op = 1'b0;
      @(negedge clk);
      chk("t4_tie_ready0", 32'(req0_ready), 32'd1);
      chk("t4_tie_ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();

`ifdef ARB_GRANT_CNT_EN
      // 300 requester-0 transactions saturate its counter at 255
      reset = 1'b1;
      #2;
      chk("t5_cnt0_reset", 32'(gnt_cnt0), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      grant_log.delete();
      begin
         int n = 0;
         req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h44; req0_op = 1'b0;
         while (grant_log.size() < 300 && n < 1200) begin
            tick();
            n++;
         end
         req0_valid = 1'b0;
         if (grant_log.size() < 300) chk("t5_grant_timeout", 32'(grant_log.size()), 32'd300);
      end
      wait_idle();
      chk("t5_gnt_cnt0", 32'(gnt_cnt0), 32'd255);
      chk("t5_gnt_cnt1", 32'(gnt_cnt1), 32'd0);
`endif

      repeat (2) tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
